// File: rtl/node_pwr_scheduler.sv
// Staggered per-node P12V enable scheduler: one node at a time on, power-good timeout,
// latched power-good-loss faults, and ordered highest-index-first power-off.
module node_pwr_scheduler #(
  parameter int unsigned NODES         = 4,
  parameter int unsigned STAGGER_MS    = 20,
  parameter int unsigned PG_TIMEOUT_MS = 150,
  parameter int unsigned OFF_GAP_MS    = 10
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iTick_1ms,
  input  logic             iBulk_EN,
  input  logic [NODES-1:0] iNode_Req,
  input  logic [NODES-1:0] iNode_PWRGD,
  input  logic             iFault_Clear,
  output logic [NODES-1:0] oNode_EN,
  output logic [NODES-1:0] oNode_Fault,
  output logic             oAll_PWRGD,
  output logic             oBusy,
  output logic [3:0]       oDBG_FSM
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StSelect  = 3'd1;
  localparam logic [2:0] StWaitPg  = 3'd2;
  localparam logic [2:0] StStagger = 3'd3;
  localparam logic [2:0] StOn      = 3'd4;
  localparam logic [2:0] StOff     = 3'd5;
  localparam logic [2:0] StOffGap  = 3'd6;

  localparam logic [NODES-1:0] OneHot0 = NODES'(1);

  logic [2:0]       state_q, state_d;
  logic [15:0]      timer_q, timer_d;
  logic             entry_q;
  logic [2:0]       cur_q, cur_d;
  logic [NODES-1:0] en_q, en_d;
  logic [NODES-1:0] fault_q, fault_d;
  logic [NODES-1:0] pg_seen_q, pg_seen_d;
  logic             all_pg_q, all_pg_d;

  logic [NODES-1:0] eligible, pg_loss, cur_mask, low_mask, hi_mask;
  logic [2:0]       low_idx, hi_idx;
  logic             any_elig, tick_cnt;
  logic [16:0]      timer_inc;
  logic             pg_done, stagger_done, gap_done;

  assign eligible  = iNode_Req & ~en_q & ~fault_q;
  assign any_elig  = |eligible;
  assign pg_loss   = pg_seen_q & en_q & ~iNode_PWRGD;
  assign cur_mask  = OneHot0 << cur_q;
  assign low_mask  = OneHot0 << low_idx;
  assign hi_mask   = OneHot0 << hi_idx;

  // The first cycle in a state never counts a tick, so every wait is a whole number of ticks.
  assign tick_cnt     = iTick_1ms & ~entry_q;
  assign timer_inc    = {1'b0, timer_q} + 17'd1;
  assign pg_done      = tick_cnt && (timer_inc >= 17'(PG_TIMEOUT_MS));
  assign stagger_done = tick_cnt && (timer_inc >= 17'(STAGGER_MS));
  assign gap_done     = tick_cnt && (timer_inc >= 17'(OFF_GAP_MS));

  always_comb begin
    low_idx = 3'd0;
    for (int i = int'(NODES) - 1; i >= 0; i--) begin
      if (eligible[i]) low_idx = 3'(i);
    end
  end

  always_comb begin
    hi_idx = 3'd0;
    for (int i = 0; i < int'(NODES); i++) begin
      if (en_q[i]) hi_idx = 3'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    en_d    = en_q;
    fault_d = fault_q;
    if (iFault_Clear) fault_d = '0;

    if (!iBulk_EN && (state_q inside {StSelect, StWaitPg, StStagger, StOn})) begin
      state_d = StOff;
    end else begin
      case (state_q)
        StIdle: begin
          en_d = '0;
          if (iBulk_EN && any_elig) state_d = StSelect;
        end
        StSelect: begin
          if (any_elig) begin
            cur_d   = low_idx;
            en_d    = en_d | low_mask;
            state_d = StWaitPg;
          end else begin
            state_d = StOn;
          end
        end
        StWaitPg: begin
          if (|(iNode_PWRGD & cur_mask)) begin
            state_d = StStagger;
          end else if (pg_done) begin
            en_d    = en_d & ~cur_mask;
            fault_d = fault_d | cur_mask;
            state_d = StStagger;
          end
        end
        StStagger: begin
          if (stagger_done) state_d = StSelect;
        end
        StOn: begin
          // A dropped request turns its node off immediately, bypassing the off sequence.
          en_d = en_d & iNode_Req;
          if (any_elig) state_d = StSelect;
        end
        StOff: begin
          en_d    = en_d & ~hi_mask;
          state_d = StOffGap;
        end
        StOffGap: begin
          if (gap_done) state_d = (|en_q) ? StOff : StIdle;
        end
        default: begin
          en_d    = '0;
          state_d = StIdle;
        end
      endcase
    end

    // Applied last so a fault raised this cycle wins over a simultaneous clear.
    if (state_q inside {StSelect, StStagger, StOn}) begin
      en_d    = en_d & ~pg_loss;
      fault_d = fault_d | pg_loss;
    end
  end

  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (tick_cnt && (timer_q != 16'hFFFF)) begin
      timer_d = timer_q + 16'd1;
    end
  end

  assign pg_seen_d = en_q & (pg_seen_q | iNode_PWRGD);
  assign all_pg_d  = (state_q == StOn) & (|en_q) & ~(|(en_q & ~iNode_PWRGD));

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      entry_q   <= 1'b0;
      cur_q     <= '0;
      en_q      <= '0;
      fault_q   <= '0;
      pg_seen_q <= '0;
      all_pg_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      entry_q   <= (state_d != state_q);
      cur_q     <= cur_d;
      en_q      <= en_d;
      fault_q   <= fault_d;
      pg_seen_q <= pg_seen_d;
      all_pg_q  <= all_pg_d;
    end
  end

  assign oNode_EN    = en_q;
  assign oNode_Fault = fault_q;
  assign oAll_PWRGD  = all_pg_q;
  assign oBusy       = state_q inside {StSelect, StWaitPg, StStagger, StOff, StOffGap};
  assign oDBG_FSM    = {1'b0, state_q};

endmodule

// File: tb/tb_node_pwr_scheduler.sv
// Directed bench for node_pwr_scheduler: tick generator plus a per-node power-good model
// that asserts PG a fixed number of ticks after each enable.
`timescale 1ns / 1ps
module tb_node_pwr_scheduler;

  localparam int TickDiv = 4;
  localparam int PgDelay = 5;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       bulk;
  logic [3:0] req;
  logic [3:0] pwrgd;
  logic       fclr;
  logic [3:0] oNode_EN;
  logic [3:0] oNode_Fault;
  logic       oAll_PWRGD;
  logic       oBusy;
  logic [3:0] oDBG_FSM;

  logic [3:0] pg_ok;
  int         ticks;
  int         div;
  int         pg_cnt [4];
  int         vecs;
  int         errs;

  node_pwr_scheduler #(
    .NODES        (4),
    .STAGGER_MS   (20),
    .PG_TIMEOUT_MS(150),
    .OFF_GAP_MS   (10)
  ) dut (
    .iClk        (clk),
    .iRst        (rst),
    .iTick_1ms   (tick),
    .iBulk_EN    (bulk),
    .iNode_Req   (req),
    .iNode_PWRGD (pwrgd),
    .iFault_Clear(fclr),
    .oNode_EN    (oNode_EN),
    .oNode_Fault (oNode_Fault),
    .oAll_PWRGD  (oAll_PWRGD),
    .oBusy       (oBusy),
    .oDBG_FSM    (oDBG_FSM)
  );

  initial clk = 1'b0;
  always #250 clk = ~clk;

  // Tick strobe and PG model both update on the falling edge, away from the DUT's edge.
  always @(negedge clk) begin
    tick = 1'b0;
    div  = div + 1;
    if (div == TickDiv) begin
      div   = 0;
      tick  = 1'b1;
      ticks = ticks + 1;
    end
    for (int i = 0; i < 4; i++) begin
      if (oNode_EN[i] !== 1'b1) pg_cnt[i] = 0;
      else if (tick && pg_cnt[i] < PgDelay) pg_cnt[i] = pg_cnt[i] + 1;
      pwrgd[i] = (oNode_EN[i] === 1'b1) && (pg_cnt[i] >= PgDelay) && pg_ok[i];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench just after an edge on which a tick was sampled.
  task automatic tick_sync();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!tick && n < 16);
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    bulk  = 1'b0;
    req   = 4'h0;
    fclr  = 1'b0;
    pg_ok = 4'hF;
    repeat (3) step();
    vecs++; if (oNode_EN !== 4'h0) begin errs++; $display("FAIL reset_en: got %h want 0", oNode_EN); end
    vecs++; if (oNode_Fault !== 4'h0) begin errs++; $display("FAIL reset_fault: got %h want 0", oNode_Fault); end
    vecs++; if (oAll_PWRGD !== 1'b0) begin errs++; $display("FAIL reset_allpg: got %b want 0", oAll_PWRGD); end
    vecs++; if (oBusy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", oBusy); end
    vecs++; if (oDBG_FSM !== 4'd0) begin errs++; $display("FAIL reset_fsm: got %0d want 0", oDBG_FSM); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_power_on();
    int t_prev, n;
    logic [3:0] m;
    req   = 4'hF;
    pg_ok = 4'hF;
    bulk  = 1'b1;
    step();
    vecs++; if (oDBG_FSM !== 4'd1) begin errs++; $display("FAIL on_select: got %0d want 1", oDBG_FSM); end
    vecs++; if (oNode_EN !== 4'h0) begin errs++; $display("FAIL on_en_early: got %h want 0", oNode_EN); end
    step();
    vecs++; if (oNode_EN !== 4'h1) begin errs++; $display("FAIL on_en0: got %h want 1", oNode_EN); end
    vecs++; if (oDBG_FSM !== 4'd2) begin errs++; $display("FAIL on_waitpg: got %0d want 2", oDBG_FSM); end
    t_prev = ticks;
    for (int i = 1; i < 4; i++) begin
      n = 0;
      while (oNode_EN[i] !== 1'b1 && n < 400) begin step(); n++; end
      m = 4'((1 << (i + 1)) - 1);
      vecs++; if (oNode_EN !== m) begin errs++; $display("FAIL on_order%0d: got %h want %h", i, oNode_EN, m); end
      vecs++; if (ticks - t_prev != 25) begin errs++; $display("FAIL on_gap%0d: got %0d want 25 ticks", i, ticks - t_prev); end
      t_prev = ticks;
    end
    n = 0;
    while (oDBG_FSM !== 4'd4 && n < 400) begin step(); n++; end
    vecs++; if (oDBG_FSM !== 4'd4) begin errs++; $display("FAIL on_steady: got %0d want 4", oDBG_FSM); end
    step();
    vecs++; if (oAll_PWRGD !== 1'b1) begin errs++; $display("FAIL on_allpg: got %b want 1", oAll_PWRGD); end
    vecs++; if (oBusy !== 1'b0) begin errs++; $display("FAIL on_busy: got %b want 0", oBusy); end
  endtask

  task automatic test_pg_loss();
    int n;
    pg_ok[1] = 1'b0;
    step();
    vecs++; if (oNode_EN !== 4'hD) begin errs++; $display("FAIL loss_en: got %h want d", oNode_EN); end
    vecs++; if (oNode_Fault !== 4'h2) begin errs++; $display("FAIL loss_fault: got %h want 2", oNode_Fault); end
    vecs++; if (oDBG_FSM !== 4'd4) begin errs++; $display("FAIL loss_state: got %0d want 4", oDBG_FSM); end
    step();
    vecs++; if (oAll_PWRGD !== 1'b1) begin errs++; $display("FAIL loss_allpg: got %b want 1", oAll_PWRGD); end
    fclr = 1'b1;
    step();
    fclr     = 1'b0;
    pg_ok[1] = 1'b1;
    vecs++; if (oNode_Fault !== 4'h0) begin errs++; $display("FAIL clr_fault: got %h want 0", oNode_Fault); end
    step();
    vecs++; if (oDBG_FSM !== 4'd1) begin errs++; $display("FAIL clr_select: got %0d want 1", oDBG_FSM); end
    step();
    vecs++; if (oNode_EN !== 4'hF) begin errs++; $display("FAIL clr_reen: got %h want f", oNode_EN); end
    n = 0;
    while (oDBG_FSM !== 4'd4 && n < 400) begin step(); n++; end
    step();
    vecs++; if (oAll_PWRGD !== 1'b1) begin errs++; $display("FAIL clr_allpg: got %b want 1", oAll_PWRGD); end
  endtask

  task automatic test_req_drop();
    int n;
    req = 4'h7;
    step();
    vecs++; if (oNode_EN !== 4'h7) begin errs++; $display("FAIL drop_en: got %h want 7", oNode_EN); end
    vecs++; if (oNode_Fault !== 4'h0) begin errs++; $display("FAIL drop_fault: got %h want 0", oNode_Fault); end
    vecs++; if (oDBG_FSM !== 4'd4) begin errs++; $display("FAIL drop_state: got %0d want 4", oDBG_FSM); end
    req = 4'hF;
    step();
    vecs++; if (oDBG_FSM !== 4'd1) begin errs++; $display("FAIL rereq_select: got %0d want 1", oDBG_FSM); end
    n = 0;
    while (oDBG_FSM !== 4'd4 && n < 400) begin step(); n++; end
    vecs++; if (oNode_EN !== 4'hF) begin errs++; $display("FAIL rereq_en: got %h want f", oNode_EN); end
    step();
  endtask

  task automatic test_power_off();
    int t_prev, n;
    logic [3:0] m;
    tick_sync();
    bulk = 1'b0;
    step();
    vecs++; if (oDBG_FSM !== 4'd5) begin errs++; $display("FAIL off_state: got %0d want 5", oDBG_FSM); end
    step();
    vecs++; if (oNode_EN !== 4'h7) begin errs++; $display("FAIL off_en3: got %h want 7", oNode_EN); end
    vecs++; if (oDBG_FSM !== 4'd6) begin errs++; $display("FAIL off_gapstate: got %0d want 6", oDBG_FSM); end
    t_prev = ticks;
    for (int i = 2; i >= 0; i--) begin
      n = 0;
      while (oNode_EN[i] !== 1'b0 && n < 200) begin step(); n++; end
      m = 4'((1 << i) - 1);
      vecs++; if (oNode_EN !== m) begin errs++; $display("FAIL off_order%0d: got %h want %h", i, oNode_EN, m); end
      vecs++; if (ticks - t_prev != 10) begin errs++; $display("FAIL off_gap%0d: got %0d want 10 ticks", i, ticks - t_prev); end
      t_prev = ticks;
    end
    n = 0;
    while (oDBG_FSM !== 4'd0 && n < 200) begin step(); n++; end
    vecs++; if (ticks - t_prev != 10) begin errs++; $display("FAIL off_idle: got %0d want 10 ticks", ticks - t_prev); end
    vecs++; if (oBusy !== 1'b0) begin errs++; $display("FAIL off_busy: got %b want 0", oBusy); end
  endtask

  task automatic test_pg_timeout();
    int t_rise, t_fall, n;
    pg_ok = 4'hB;
    bulk  = 1'b1;
    n = 0;
    while (oNode_EN[2] !== 1'b1 && n < 1000) begin step(); n++; end
    t_rise = ticks;
    vecs++; if (oNode_EN !== 4'h7) begin errs++; $display("FAIL to_en2: got %h want 7", oNode_EN); end
    n = 0;
    while (oNode_EN[2] !== 1'b0 && n < 1000) begin step(); n++; end
    t_fall = ticks;
    vecs++; if (t_fall - t_rise != 150) begin errs++; $display("FAIL to_len: got %0d want 150 ticks", t_fall - t_rise); end
    vecs++; if (oNode_Fault !== 4'h4) begin errs++; $display("FAIL to_fault: got %h want 4", oNode_Fault); end
    n = 0;
    while (oNode_EN[3] !== 1'b1 && n < 400) begin step(); n++; end
    vecs++; if (ticks - t_fall != 20) begin errs++; $display("FAIL to_next: got %0d want 20 ticks", ticks - t_fall); end
    n = 0;
    while (oDBG_FSM !== 4'd4 && n < 400) begin step(); n++; end
    step();
    vecs++; if (oNode_EN !== 4'hB) begin errs++; $display("FAIL to_final_en: got %h want b", oNode_EN); end
    vecs++; if (oAll_PWRGD !== 1'b1) begin errs++; $display("FAIL to_allpg: got %b want 1", oAll_PWRGD); end
    bulk = 1'b0;
    n = 0;
    while (oDBG_FSM !== 4'd0 && n < 1000) begin step(); n++; end
    vecs++; if (oNode_EN !== 4'h0) begin errs++; $display("FAIL to_down: got %h want 0", oNode_EN); end
    fclr = 1'b1;
    step();
    fclr  = 1'b0;
    pg_ok = 4'hF;
    vecs++; if (oNode_Fault !== 4'h0) begin errs++; $display("FAIL to_clr: got %h want 0", oNode_Fault); end
  endtask

  task automatic test_abort();
    int t_off, n;
    bulk = 1'b1;
    n = 0;
    while (oDBG_FSM !== 4'd3 && n < 400) begin step(); n++; end
    tick_sync();
    bulk = 1'b0;
    step();
    vecs++; if (oDBG_FSM !== 4'd5) begin errs++; $display("FAIL abort_state: got %0d want 5", oDBG_FSM); end
    step();
    vecs++; if (oNode_EN !== 4'h0) begin errs++; $display("FAIL abort_en: got %h want 0", oNode_EN); end
    t_off = ticks;
    n = 0;
    while (oDBG_FSM !== 4'd0 && n < 200) begin step(); n++; end
    vecs++; if (ticks - t_off != 10) begin errs++; $display("FAIL abort_gap: got %0d want 10 ticks", ticks - t_off); end
  endtask

  task automatic test_reset_mid();
    int n;
    bulk = 1'b1;
    n = 0;
    while (oDBG_FSM !== 4'd2 && n < 100) begin step(); n++; end
    vecs++; if (oNode_EN !== 4'h1) begin errs++; $display("FAIL rst_pre: got %h want 1", oNode_EN); end
    rst = 1'b1;
    step();
    vecs++; if (oNode_EN !== 4'h0) begin errs++; $display("FAIL rst_en: got %h want 0", oNode_EN); end
    vecs++; if (oDBG_FSM !== 4'd0) begin errs++; $display("FAIL rst_fsm: got %0d want 0", oDBG_FSM); end
    vecs++; if (oBusy !== 1'b0) begin errs++; $display("FAIL rst_busy: got %b want 0", oBusy); end
    rst  = 1'b0;
    bulk = 1'b0;
    step();
  endtask

  initial begin
    vecs  = 0;
    errs  = 0;
    ticks = 0;
    div   = 0;
    tick  = 1'b0;
    pwrgd = 4'h0;
    rst   = 1'b1;
    bulk  = 1'b0;
    req   = 4'h0;
    fclr  = 1'b0;
    pg_ok = 4'hF;
    test_reset();
    test_power_on();
    test_pg_loss();
    test_req_drop();
    test_power_off();
    test_pg_timeout();
    test_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
